// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment codes are {a,b,c,d,e,f,g}, active-low.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_DASH  = SEG_MINUS;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_t;

    // Nibbles needed to hold any IN_W-bit value in BCD, with headroom.
    function automatic int conv_digits(input int w);
        return (w + 2) / 3 + 1;
    endfunction

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_conv.sv
// Iterative double-dabble converter: one add-3/shift step per cycle,
// followed by a single COMMIT cycle where the BCD result is valid.
module bcd_seq_conv
    import sevenseg_pkg::*;
#(
    parameter int IN_W = 13,
    parameter int CD   = conv_digits(IN_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IN_W-1:0]   bin,
    output logic              busy,
    output logic              done,
    output logic [4*CD-1:0]   bcd
);

    localparam int CW = $clog2(IN_W + 1);

    conv_state_t     state;
    conv_state_t     state_nxt;
    logic [IN_W-1:0] bin_q;
    logic [4*CD-1:0] bcd_q;
    logic [4*CD-1:0] adj;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE: begin
                if (start) begin
                    state_nxt = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                if (cnt == CW'(IN_W - 1)) begin
                    state_nxt = CONV_COMMIT;
                end
            end
            CONV_COMMIT: state_nxt = CONV_IDLE;
            default:     state_nxt = CONV_IDLE;
        endcase
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < CD; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt   <= '0;
        end else if (state == CONV_IDLE && start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt   <= '0;
        end else if (state == CONV_SHIFT) begin
            bcd_q <= {adj[4*CD-2:0], bin_q[IN_W-1]};
            bin_q <= {bin_q[IN_W-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
        end
    end

    assign busy = (state != CONV_IDLE);
    assign done = (state == CONV_COMMIT);
    assign bcd  = bcd_q;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver: load latch, BCD formatting
// (sign, blanking, overflow) and the digit scan/output registers.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int IN_W         = 13,
    parameter int REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   value_in,
    input  logic              load,
    input  logic              signed_mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_in,
    output logic              busy,
    output logic [DIGITS-1:0] AN,
    output logic [6:0]        SEG,
    output logic              DP
);

    localparam int CD = conv_digits(IN_W);
    localparam int DW = (CD > DIGITS) ? CD : DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic              start;
    logic              conv_busy;
    logic              conv_done;
    logic [IN_W-1:0]   mag;
    logic [4*CD-1:0]   conv_bcd;
    logic [4*DW-1:0]   bcd_ext;

    logic              sgn_q;
    logic              neg_q;
    logic              blank_q;
    logic [DIGITS-1:0] dp_q;

    logic              ovf;
    int                msd;
    logic [6:0]        seg_nxt  [DIGITS];
    logic [6:0]        seg_disp [DIGITS];
    logic [DIGITS-1:0] dp_disp;

    logic [REFRESH_BITS-1:0] presc;
    logic [IW-1:0]           idx;

    assign start = load & ~conv_busy;
    assign busy  = conv_busy;

    // Magnitude fits IN_W unsigned bits, including -2^(IN_W-1).
    assign mag = (signed_mode && value_in[IN_W-1]) ?
                 (~value_in + IN_W'(1)) : value_in;

    bcd_seq_conv #(
        .IN_W (IN_W),
        .CD   (CD)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            blank_q <= 1'b1;
            dp_q    <= '0;
        end else if (start) begin
            sgn_q   <= signed_mode;
            neg_q   <= signed_mode & value_in[IN_W-1];
            blank_q <= blank_lz;
            dp_q    <= dp_in;
        end
    end

    assign bcd_ext = (4*DW)'(conv_bcd);

    // Signed mode reserves the top digit for the sign, so its limit drops.
    always_comb begin
        ovf = 1'b0;
        msd = 0;
        for (int i = 0; i < DW; i++) begin
            if (bcd_ext[4*i +: 4] != 4'd0) begin
                if (i >= (sgn_q ? DIGITS - 1 : DIGITS)) begin
                    ovf = 1'b1;
                end else begin
                    msd = i;
                end
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            seg_nxt[i] = bcd_to_seg(bcd_ext[4*i +: 4]);
            if (ovf) begin
                seg_nxt[i] = SEG_DASH;
            end else if (blank_q && i > msd) begin
                seg_nxt[i] = (neg_q && i == msd + 1) ? SEG_MINUS : SEG_BLANK;
            end else if (!blank_q && neg_q && i == DIGITS - 1) begin
                seg_nxt[i] = SEG_MINUS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_disp[i] <= (i == 0) ? bcd_to_seg(4'd0) : SEG_BLANK;
            end
            dp_disp <= '0;
        end else if (conv_done) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_disp[i] <= seg_nxt[i];
            end
            dp_disp <= dp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= IW'(DIGITS - 1);
            AN    <= '1;
            SEG   <= SEG_BLANK;
            DP    <= 1'b1;
        end else begin
            presc <= presc + REFRESH_BITS'(1);
            if (&presc) begin
                idx <= (idx == '0) ? IW'(DIGITS - 1) : idx - IW'(1);
            end
            AN  <= ~(DIGITS'(1) << idx);
            SEG <= seg_disp[idx];
            DP  <= ~dp_disp[idx];
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver with a fast refresh.
// Expected digit codes are queued at load time and checked per scan slot.
module tb_sevenseg_scan_driver;

    localparam int DIGITS = 4;
    localparam int IN_W   = 13;
    localparam int RB     = 2;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b1111110;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dp_n;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [IN_W-1:0]   value_in;
    logic              load;
    logic              signed_mode;
    logic              blank_lz;
    logic [DIGITS-1:0] dp_in;
    logic              busy;
    logic [DIGITS-1:0] AN;
    logic [6:0]        SEG;
    logic              DP;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    sevenseg_scan_driver #(
        .DIGITS       (DIGITS),
        .IN_W         (IN_W),
        .REFRESH_BITS (RB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .load        (load),
        .signed_mode (signed_mode),
        .blank_lz    (blank_lz),
        .dp_in       (dp_in),
        .busy        (busy),
        .AN          (AN),
        .SEG         (SEG),
        .DP          (DP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [6:0] d3, input logic [6:0] d2,
                            input logic [6:0] d1, input logic [6:0] d0,
                            input logic [3:0] dp_n);
        exp_t e;
        e.seg  = {d3, d2, d1, d0};
        e.dp_n = dp_n;
        sb.push_back(e);
    endtask

    task automatic drive_load(input logic [IN_W-1:0] v, input logic s,
                              input logic b, input logic [3:0] d);
        @(negedge clk);
        value_in    = v;
        signed_mode = s;
        blank_lz    = b;
        dp_in       = d;
        load        = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy stuck high", name);
        end
        @(negedge clk);
    endtask

    task automatic check_display(input string name);
        exp_t       e;
        int         n;
        logic [3:0] an_exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        for (int d = 3; d >= 0; d--) begin
            an_exp = ~(4'b0001 << d);
            n = 0;
            while (AN !== an_exp && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (AN !== an_exp) begin
                errors++;
                $display("FAIL %s an%0d: got %b want %b", name, d, AN, an_exp);
            end else begin
                checks++;
                if (SEG !== e.seg[d]) begin
                    errors++;
                    $display("FAIL %s seg%0d: got %b want %b",
                             name, d, SEG, e.seg[d]);
                end
                checks++;
                if (DP !== e.dp_n[d]) begin
                    errors++;
                    $display("FAIL %s dp%0d: got %b want %b",
                             name, d, DP, e.dp_n[d]);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %b want 0", name, busy);
        end
        checks++;
        if (AN !== 4'b1111) begin
            errors++;
            $display("FAIL %s an: got %b want 1111", name, AN);
        end
        checks++;
        if (SEG !== SB) begin
            errors++;
            $display("FAIL %s seg: got %b want %b", name, SEG, SB);
        end
        checks++;
        if (DP !== 1'b1) begin
            errors++;
            $display("FAIL %s dp: got %b want 1", name, DP);
        end
    endtask

    task automatic test_reset();
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        int         dig;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            dig     = 3 - (k - 1) / 4;
            an_exp  = ~(4'b0001 << dig);
            seg_exp = (dig == 0) ? S0 : SB;
            checks++;
            if (AN !== an_exp) begin
                errors++;
                $display("FAIL scan_an k%0d: got %b want %b", k, AN, an_exp);
            end
            checks++;
            if (SEG !== seg_exp) begin
                errors++;
                $display("FAIL scan_seg k%0d: got %b want %b", k, SEG, seg_exp);
            end
        end
        push_exp(SB, SB, SB, S0, 4'b1111);
        check_display("reset_disp");
    endtask

    task automatic test_unsigned();
        int n;
        push_exp(S1, S2, S3, S4, 4'b1111);
        drive_load(13'd1234, 1'b0, 1'b0, 4'b0000);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 14) begin
            errors++;
            $display("FAIL busy_len: got %0d want 14", n);
        end
        @(negedge clk);
        check_display("u1234");
    endtask

    task automatic test_blank_dp();
        push_exp(SB, SB, S4, S2, 4'b1101);
        drive_load(13'd42, 1'b0, 1'b1, 4'b0010);
        wait_idle("u42");
        check_display("u42");
    endtask

    task automatic test_signed();
        push_exp(SB, SM, S5, S7, 4'b1111);
        drive_load(13'h1FC7, 1'b1, 1'b1, 4'b0000);
        wait_idle("s-57");
        check_display("s-57");
        push_exp(SM, S9, S9, S9, 4'b1111);
        drive_load(13'h1C19, 1'b1, 1'b0, 4'b0000);
        wait_idle("s-999");
        check_display("s-999");
    endtask

    task automatic test_overflow();
        push_exp(SM, SM, SM, SM, 4'b1110);
        drive_load(13'd1000, 1'b1, 1'b1, 4'b0001);
        wait_idle("ovf1000");
        check_display("ovf1000");
        push_exp(S8, S1, S9, S1, 4'b1111);
        drive_load(13'd8191, 1'b0, 1'b1, 4'b0000);
        wait_idle("u8191");
        check_display("u8191");
    endtask

    task automatic test_back_to_back();
        int n;
        drive_load(13'd42, 1'b0, 1'b1, 4'b0000);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        push_exp(SB, SB, S9, S9, 4'b1111);
        value_in    = 13'd99;
        signed_mode = 1'b0;
        blank_lz    = 1'b1;
        dp_in       = 4'b0000;
        load        = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy %b want 1", busy);
        end
        wait_idle("b2b");
        check_display("b2b99");
    endtask

    task automatic test_abort();
        drive_load(13'd1234, 1'b0, 1'b0, 4'b0000);
        repeat (3) @(negedge clk);
        value_in = 13'd5;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got %b want 1", busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        push_exp(SB, SB, SB, S0, 4'b1111);
        repeat (20) @(negedge clk);
        check_display("abort_disp");
        push_exp(SB, SB, SB, S7, 4'b1111);
        drive_load(13'd7, 1'b0, 1'b1, 4'b0000);
        wait_idle("u7");
        check_display("u7");
    endtask

    initial begin
        rst_n       = 1'b0;
        value_in    = '0;
        load        = 1'b0;
        signed_mode = 1'b0;
        blank_lz    = 1'b0;
        dp_in       = '0;
        test_reset();
        test_unsigned();
        test_blank_dp();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_abort();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left: %0d entries", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sevenseg_scan_driver.md
# sevenseg_scan_driver

Parametrised multiplexed seven-segment display driver: accepts a binary value on a load strobe, converts it to BCD with a sequential double-dabble engine, and scans the result across `DIGITS` common-anode digits. Supports two's-complement signed mode with a minus sign, leading-zero blanking, per-digit decimal points and overflow indication. It sits between the datapath debug/result registers and the board display pins.

## Interface
- `DIGITS`, 4: number of display digits (2..8).
- `IN_W`, 13: binary input width (4..26).
- `REFRESH_BITS`, 18: each digit is lit for 2^REFRESH_BITS clk cycles.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `value_in`  in  IN_W  binary value to display.
- `load`  in  1  capture request; accepted only when `busy`=0.
- `signed_mode`  in  1  1: `value_in` is two's complement.
- `blank_lz`  in  1  1: blank leading zeros.
- `dp_in`  in  DIGITS  decimal-point enables, bit i = digit i (digit 0 rightmost).
- `busy`  out  1  conversion in progress.
- `AN`  out  DIGITS  anode enables, active-low one-hot; bit i = digit i.
- `SEG`  out  7  segments {a,b,c,d,e,f,g}, active-low ("0" = 0000001).
- `DP`  out  1  decimal point, active-low.

## Operation
- Load: `load`=1 with `busy`=0 latches `value_in`, `signed_mode`, `blank_lz`, `dp_in`; `load` while `busy`=1 is ignored (no queueing).
- Signed mode: negative values are converted as magnitude; -2^(IN_W-1) is legal (magnitude in IN_W bits unsigned).
- Converter FSM: IDLE -> SHIFT (IN_W steps: add 3 to each BCD nibble >=5, then shift left one bit) -> COMMIT -> IDLE. Internal BCD width CONV_DIGITS = ceil(IN_W/3)+1 nibbles.
- Overflow: unsigned limit 10^DIGITS-1; signed limit 10^(DIGITS-1)-1 for either sign. Exceeded -> every digit shows dash (0111111... g only = 1111110), DPs still per `dp_in`.
- COMMIT atomically updates the display registers (per-digit segment codes plus DP); the display never shows a partial result.
- Blanking: with `blank_lz`=1, digits above the most significant nonzero digit show 1111111; digit 0 always shown. Minus sign (1111110) goes immediately left of the most significant shown digit when blanking, else in digit DIGITS-1.
- Scan: prescaler counts 0..2^REFRESH_BITS-1; on wrap the digit index decrements DIGITS-1 -> ... -> 0 -> DIGITS-1 (leftmost first).
- `AN`, `SEG`, `DP` are registered from the digit index and display registers.

## Timing
- Reset values: `busy`=0, `AN`=all 1, `SEG`=1111111, `DP`=1, prescaler 0, digit index DIGITS-1. Display registers hold unsigned 0 with `blank_lz`=1 and no DPs, so only digit 0 shows "0".
- Load accepted at edge E0 -> `busy`=1 after E0; shift steps on E1..E_IN_W; COMMIT at E_(IN_W+1) -> `busy`=0 and display registers updated. `busy` is high for exactly IN_W+1 cycles.
- A new load is accepted in the first cycle `busy`=0; back-to-back conversions have no dead cycle.
- Outputs reflect updated display registers one cycle after COMMIT, mid-slot if necessary; the scan phase is not restarted.
- `rst_n`=0 mid-conversion aborts it, discards the partial result and restores reset values on the next edge.

## Structure
- Package `sevenseg_pkg`: constants SEG_BLANK=1111111, SEG_MINUS=1111110, SEG_DASH=SEG_MINUS, function `bcd_to_seg` (nibble -> active-low code, values >9 -> SEG_BLANK), and the CONV_DIGITS width function.
- Sub-module `bcd_seq_conv`: iterative double-dabble with `start`/`done` and parameter IN_W. The top holds the load latch, overflow/blank/sign formatting, scan counter and output registers.

## Test plan
Bench uses REFRESH_BITS=2, DIGITS=4, IN_W=13.
- Reset then idle -> `AN` cycles 0111,1011,1101,1110 every 4 cycles; `SEG`=1111111 except digit 0 = 0000001.
- Load 1234, unsigned, `blank_lz`=0 -> `busy` high 14 cycles; then digits 3..0 = 1001111, 0010010, 0000110, 1001100.
- Load 42, `blank_lz`=1, `dp_in`=0010 -> digits 3,2 blank; digit 1 = 1001100 with `DP`=0; digit 0 = 0010010.
- Load 0x1FC7 (-57), signed, `blank_lz`=1 -> digit 3 blank, digit 2 = 1111110, digits 1,0 = 0100100, 0001111.
- Load 1000 signed (overflow) -> all four digits 1111110. Load 8191 unsigned -> 0000000, 1001111, 0000100, 1001111.
- Load 1234, pulse `load` with 5 at cycle 5 (ignored), assert `rst_n`=0 at cycle 8 -> no commit, outputs at reset values, `busy`=0; a later load of 7 displays "7".
